pwm_ramp_sequencer: RTL and testbench

Bus-master controller that drives the PWM peripheral's register bus to program a channel's period and then ramp its duty cycle toward a target in fixed steps at a programmable interval. It sits between a simple start/parameter command port and the PWM's wen/ren/addr/wdata/strobe bus. The PWM itself is left unchanged: the sequencer only issues ordinary register writes and honours the slave's stall and error responses.

---
 rtl/pwm_ramp_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_pwm_ramp_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_sequencer.sv
// Bus-master that programs a PWM channel's period, then walks its duty register
// toward a target in clamped steps, one write every `interval` idle cycles.
module pwm_ramp_sequencer #(
  parameter int NUM_CHANNELS = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PERIOD_BASE = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] DUTY_BASE = 32'h0000_0010
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            start,
  input  logic [$clog2(NUM_CHANNELS)-1:0] chan,
  input  logic [DATA_WIDTH-1:0]           period,
  input  logic [DATA_WIDTH-1:0]           target,
  input  logic [DATA_WIDTH-1:0]           step,
  input  logic [15:0]                     interval,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic                            wen,
  output logic                            ren,
  output logic [DATA_WIDTH/8-1:0]         strobe,
  output logic [ADDR_WIDTH-1:0]           addr,
  output logic [DATA_WIDTH-1:0]           wdata,
  input  logic [DATA_WIDTH-1:0]           rdata,
  input  logic                            error,
  input  logic                            request_stall
);

  localparam int CW = $clog2(NUM_CHANNELS);

  typedef enum logic [2:0] {IDLE, WR_PERIOD, WR_DUTY, WAIT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           chan_q, chan_d;
  logic [DATA_WIDTH-1:0]   period_q, period_d;
  logic [DATA_WIDTH-1:0]   tgt_q, tgt_d;
  logic [DATA_WIDTH-1:0]   step_q, step_d;
  logic [15:0]             interval_q, interval_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   next_q, next_d;
  logic [DATA_WIDTH-1:0]   cur_duty_q [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   cur_duty_d [NUM_CHANNELS];
  logic                    err_q, err_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    wen_q, wen_d;
  logic [DATA_WIDTH/8-1:0] strobe_q, strobe_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    xferDone;
  logic                    rdata_unused;

  assign rdata_unused = ^rdata;
  assign xferDone = wen_q && !request_stall;

  // One extra bit of headroom so cur+step never wraps before the clamp.
  function automatic logic [DATA_WIDTH-1:0] calcNext(
    input logic [DATA_WIDTH-1:0] cur,
    input logic [DATA_WIDTH-1:0] tgt,
    input logic [DATA_WIDTH-1:0] stp
  );
    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] diff;
    sum  = {1'b0, cur} + {1'b0, stp};
    diff = {1'b0, cur} - {1'b0, tgt};
    if (cur < tgt) begin
      calcNext = (sum > {1'b0, tgt}) ? tgt : sum[DATA_WIDTH-1:0];
    end else if (cur > tgt) begin
      calcNext = ({1'b0, stp} >= diff) ? tgt : (cur - stp);
    end else begin
      calcNext = tgt;
    end
  endfunction

  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    period_d   = period_q;
    tgt_d      = tgt_q;
    step_d     = step_q;
    interval_d = interval_q;
    cnt_d      = cnt_q;
    next_d     = next_q;
    cur_duty_d = cur_duty_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          chan_d     = chan;
          period_d   = period;
          tgt_d      = (target < period) ? target : period;
          step_d     = (step == '0) ? DATA_WIDTH'(1) : step;
          interval_d = (interval == 16'd0) ? 16'd1 : interval;
          err_d      = 1'b0;
          state_d    = WR_PERIOD;
        end
      end
      WR_PERIOD: begin
        if (xferDone) begin
          if (error) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            next_d  = calcNext(cur_duty_q[chan_q], tgt_q, step_q);
            state_d = WR_DUTY;
          end
        end
      end
      WR_DUTY: begin
        if (xferDone) begin
          if (error) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            cur_duty_d[chan_q] = next_q;
            if (next_q == tgt_q) begin
              state_d = DONE;
            end else begin
              cnt_d   = interval_q;
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 16'd1) begin
          next_d  = calcNext(cur_duty_q[chan_q], tgt_q, step_q);
          state_d = WR_DUTY;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    wen_d    = (state_d == WR_PERIOD) || (state_d == WR_DUTY);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    strobe_d = wen_d ? '1 : '0;
    addr_d   = '0;
    wdata_d  = '0;
    if (state_d == WR_PERIOD) begin
      addr_d  = PERIOD_BASE + (ADDR_WIDTH'(chan_d) << 2);
      wdata_d = period_d;
    end else if (state_d == WR_DUTY) begin
      addr_d  = DUTY_BASE + (ADDR_WIDTH'(chan_d) << 2);
      wdata_d = next_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      chan_q     <= '0;
      period_q   <= '0;
      tgt_q      <= '0;
      step_q     <= '0;
      interval_q <= '0;
      cnt_q      <= '0;
      next_q     <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        cur_duty_q[i] <= '0;
      end
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      wen_q    <= 1'b0;
      strobe_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      period_q   <= period_d;
      tgt_q      <= tgt_d;
      step_q     <= step_d;
      interval_q <= interval_d;
      cnt_q      <= cnt_d;
      next_q     <= next_d;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        cur_duty_q[i] <= cur_duty_d[i];
      end
      err_q    <= err_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      wen_q    <= wen_d;
      strobe_q <= strobe_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign wen    = wen_q;
  assign ren    = 1'b0;
  assign strobe = strobe_q;
  assign addr   = addr_q;
  assign wdata  = wdata_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Scoreboard bench for pwm_ramp_sequencer: directed commands push hand-computed
// bus writes and done pulses; a negedge monitor pops and checks them.
module tb_pwm_ramp_sequencer;

  localparam logic [31:0] DUTY_BASE = 32'h10;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [0:0]  chan = 1'b0;
  logic [31:0] period = '0;
  logic [31:0] target = '0;
  logic [31:0] step = '0;
  logic [15:0] interval = '0;
  logic [31:0] rdata = '0;
  logic        error = 1'b0;
  logic        request_stall = 1'b0;
  logic        busy, done, err, wen, ren;
  logic [3:0]  strobe;
  logic [31:0] addr, wdata;

  pwm_ramp_sequencer dut (
    .CLK(CLK), .RST(RST), .start(start), .chan(chan), .period(period),
    .target(target), .step(step), .interval(interval), .busy(busy),
    .done(done), .err(err), .wen(wen), .ren(ren), .strobe(strobe),
    .addr(addr), .wdata(wdata), .rdata(rdata), .error(error),
    .request_stall(request_stall)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
    int          gap;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   stallCfg = 0;
  int   errOnDuty = 0;
  int   dutyCnt = 0;
  int   cycle = 0;
  int   lastXfer = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic failNow(input string name, input string msg);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: %s", name, msg);
  endtask

  task automatic pushWrite(input logic [31:0] a, input logic [31:0] d, input int gap);
    exp_t e;
    e.kind = 0; e.a = a; e.d = d; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic pushDone(input int gap);
    exp_t e;
    e.kind = 1; e.a = '0; e.d = '0; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Monitor: holds during stalls, pops on completed writes and done pulses.
  always @(negedge CLK) begin
    exp_t e;
    cycle++;
    if (!RST) begin
      if (wen && request_stall) begin
        if (exp_q.size() > 0 && exp_q[0].kind == 0) begin
          checkOutput("holdAddr", addr, exp_q[0].a);
          checkOutput("holdData", wdata, exp_q[0].d);
        end
      end else if (wen) begin
        if (exp_q.size() == 0) begin
          failNow("unexpectedWrite", $sformatf("addr=0x%0h data=%0d, nothing expected", addr, wdata));
        end else begin
          e = exp_q.pop_front();
          if (e.kind != 0) begin
            failNow("writeOrder", $sformatf("got write data=%0d, expected done pulse", wdata));
          end else begin
            checkOutput("addr", addr, e.a);
            checkOutput("wdata", wdata, e.d);
            checkOutput("strobe", {28'd0, strobe}, 32'hF);
            if (e.gap > 0) checkOutput("writeGap", cycle - lastXfer, e.gap);
          end
        end
        lastXfer = cycle;
      end else begin
        checkOutput("idleBus", {28'd0, strobe} | addr | wdata, 32'd0);
      end
      if (done) begin
        checkOutput("doneBusy", {31'd0, busy}, 32'd1);
        if (exp_q.size() == 0 || exp_q[0].kind != 1) begin
          failNow("unexpectedDone", "done pulse where none expected");
        end else begin
          e = exp_q.pop_front();
          checkOutput("doneGap", cycle - lastXfer, e.gap);
        end
      end
    end
  end

  // Slave responder: inserts stallCfg stall cycles per transfer, errors one duty write.
  initial begin : responder
    bit lastWen;
    bit inXfer;
    int stallLeft;
    lastWen = 1'b0; inXfer = 1'b0; stallLeft = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (lastWen && !request_stall) inXfer = 1'b0;
      if (wen) begin
        if (!inXfer) begin
          inXfer = 1'b1;
          stallLeft = stallCfg;
        end
        if (stallLeft > 0) begin
          request_stall = 1'b1;
          error = 1'b0;
          stallLeft--;
        end else begin
          request_stall = 1'b0;
          if (addr >= DUTY_BASE) begin
            dutyCnt++;
            error = (dutyCnt == errOnDuty);
          end else begin
            error = 1'b0;
          end
        end
      end else begin
        inXfer = 1'b0;
        request_stall = 1'b0;
        error = 1'b0;
      end
      lastWen = wen;
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (busy) failNow("idleTimeout", "sequencer still busy before new command");
  endtask

  task automatic applyStimulus(input int ch, input int p, input int t, input int s, input int iv,
                               input int stalls, input int errIdx, input int glitchAt,
                               input logic expErr);
    int n;
    waitIdle();
    stallCfg = stalls;
    errOnDuty = errIdx;
    dutyCnt = 0;
    chan = 1'(ch);
    period = 32'(p);
    target = 32'(t);
    step = 32'(s);
    interval = 16'(iv);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    n = 0;
    while (busy && n < 400) begin
      if (glitchAt > 0 && n == glitchAt) begin
        start = 1'b1;
        chan = (ch == 0) ? 1'b1 : 1'b0;
        period = 32'd999;
        target = 32'd7;
        step = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge CLK);
      n++;
    end
    start = 1'b0;
    if (n >= 400) failNow("cmdTimeout", "busy never dropped");
    checkOutput("errFlag", {31'd0, err}, {31'd0, expErr});
    checkOutput("doneAfter", {31'd0, done}, 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wen"}, {31'd0, wen}, 32'd0);
    checkOutput({tag, "_ren"}, {31'd0, ren}, 32'd0);
    checkOutput({tag, "_strobe"}, {28'd0, strobe}, 32'd0);
    checkOutput({tag, "_addr"}, addr, 32'd0);
    checkOutput({tag, "_wdata"}, wdata, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : driver
    int n;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checkAllZero("reset");
    RST = 1'b0;
    @(negedge CLK);

    // Ramp up on ch0: 30,60,90,100 four cycles apart.
    pushWrite(32'h00, 200, 0);
    pushWrite(32'h10, 30, 1);
    pushWrite(32'h10, 60, 4);
    pushWrite(32'h10, 90, 4);
    pushWrite(32'h10, 100, 4);
    pushDone(1);
    applyStimulus(0, 200, 100, 30, 3, 0, 0, 0, 1'b0);

    // Ramp down with saturation at target, interval 0 behaves as 1.
    pushWrite(32'h00, 200, 0);
    pushWrite(32'h10, 60, 1);
    pushWrite(32'h10, 20, 2);
    pushWrite(32'h10, 5, 2);
    pushDone(1);
    applyStimulus(0, 200, 5, 40, 0, 0, 0, 0, 1'b0);

    // Three stall cycles on every write to ch1.
    pushWrite(32'h04, 100, 0);
    pushWrite(32'h14, 20, 0);
    pushWrite(32'h14, 40, 0);
    pushWrite(32'h14, 50, 0);
    pushDone(1);
    applyStimulus(1, 100, 50, 20, 1, 3, 0, 0, 1'b0);

    // Error on second duty write: 35 lands, 65 rejected, no done.
    pushWrite(32'h00, 200, 0);
    pushWrite(32'h10, 35, 1);
    pushWrite(32'h10, 65, 3);
    applyStimulus(0, 200, 100, 30, 2, 0, 2, 0, 1'b1);

    // Resume from last good duty (35); err cleared by the accepted start.
    pushWrite(32'h00, 200, 0);
    pushWrite(32'h10, 65, 1);
    pushWrite(32'h10, 95, 2);
    pushWrite(32'h10, 100, 2);
    pushDone(1);
    applyStimulus(0, 200, 100, 30, 0, 0, 0, 0, 1'b0);

    // Target clamped to period; a mid-ramp start is ignored.
    pushWrite(32'h04, 250, 0);
    pushWrite(32'h14, 150, 1);
    pushWrite(32'h14, 250, 2);
    pushDone(1);
    applyStimulus(1, 250, 300, 100, 1, 0, 0, 2, 1'b0);

    // Reset during WAIT after the first duty write.
    waitIdle();
    stallCfg = 0; errOnDuty = 0; dutyCnt = 0;
    pushWrite(32'h00, 200, 0);
    pushWrite(32'h10, 90, 1);
    chan = 1'b0; period = 32'd200; target = 32'd0; step = 32'd10; interval = 16'd5;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() > 0) failNow("rstSetup", "writes before reset never seen");
    repeat (2) @(negedge CLK);
    checkOutput("inWaitBusy", {31'd0, busy}, 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    checkAllZero("midReset");
    RST = 1'b0;
    @(negedge CLK);

    // cur_duty was cleared: ramp starts from 0.
    pushWrite(32'h00, 200, 0);
    pushWrite(32'h10, 10, 1);
    pushWrite(32'h10, 20, 2);
    pushDone(1);
    applyStimulus(0, 200, 20, 10, 0, 0, 0, 0, 1'b0);

    repeat (5) @(negedge CLK);
    checkOutput("queueEmpty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
